// File: rtl/ram_pkg.sv
// Shared types and constants for the dual-port tensor buffer with zero-fill engine.
package ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Read-during-write policy for a port B read hitting a port A write.
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

endpackage

// File: rtl/ram_out_stage.sv
// Optional output register for one read port: holds data between reads, passes a one-cycle valid.
module ram_out_stage #(
    parameter int WIDTH  = 8,
    parameter bit ENABLE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    input  logic             v_in,
    output logic [WIDTH-1:0] d_out,
    output logic             v_out
);

    logic [WIDTH-1:0] d_q;
    logic             v_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= '0;
            v_q <= 1'b0;
        end else begin
            v_q <= v_in;
            if (v_in) d_q <= d_in;
        end
    end

    assign d_out = ENABLE ? d_q : d_in;
    assign v_out = ENABLE ? v_q : v_in;

endmodule

// File: rtl/ram_tdp_clr.sv
// Dual-port tensor buffer: port A read/write, port B read-only, with hardware zero-fill engine.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif

module ram_tdp_clr
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH     = `DATA_WIDTH,
    parameter int ADDR_SIZE      = `ADDR_SIZE,
    parameter int MEM_LENGTH     = 2 ** ADDR_SIZE,
    parameter int OUT_REG        = 0,
    parameter int RDW_MODE       = RDW_OLD,
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_SIZE-1:0]  addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta,
    output logic                  valida,
    input  logic                  enb,
    input  logic [ADDR_SIZE-1:0]  addrb,
    output logic [DATA_WIDTH-1:0] doutb,
    output logic                  validb,
    input  logic                  clear_req,
    output logic                  busy,
    output logic                  clear_done
);

    localparam int IDX_W = (MEM_LENGTH > 1) ? $clog2(MEM_LENGTH) : 1;
    localparam logic [ADDR_SIZE-1:0] CNT_LAST = ADDR_SIZE'(MEM_LENGTH - 1);

    logic [DATA_WIDTH-1:0] mem [MEM_LENGTH];

    state_t                state, state_nxt;
    logic                  auto_clr;
    logic [ADDR_SIZE-1:0]  clr_cnt;
    logic                  clr_wr, clr_last;
    logic                  a_hit, b_hit, a_wr, a_rd, b_rd;
    logic [IDX_W-1:0]      idx_a, idx_b, idx_c;
    logic [DATA_WIDTH-1:0] rdata_a, rdata_b;
    logic [DATA_WIDTH-1:0] douta_s0, doutb_s0;
    logic                  valida_s0, validb_s0;

    assign idx_a = addra[IDX_W-1:0];
    assign idx_b = addrb[IDX_W-1:0];
    assign idx_c = clr_cnt[IDX_W-1:0];
    assign a_hit = int'(addra) < MEM_LENGTH;
    assign b_hit = int'(addrb) < MEM_LENGTH;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clka) begin
        if (rsta) begin
            state    <= IDLE;
            auto_clr <= (CLEAR_ON_RESET != 0);
        end else begin
            state <= state_nxt;
            if (state == IDLE) auto_clr <= 1'b0;
        end
    end

    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clear_req || auto_clr) state_nxt = CLEAR;
            CLEAR:   if (clr_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == CLEAR);
        clr_wr   = busy;
        clr_last = busy && (clr_cnt == CNT_LAST);
        a_wr     = !busy && ena && wea && a_hit;
        a_rd     = !busy && ena && !wea;
        b_rd     = !busy && enb;
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            clr_cnt    <= '0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= clr_last;
            if (clr_wr) clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
        end
    end

    // NOTE: the array has no reset; contents are only defined by writes or a zero-fill.
    always_ff @(posedge clka) begin
        if (!rsta) begin
            if (clr_wr)    mem[idx_c] <= '0;
            else if (a_wr) mem[idx_a] <= dina;
        end
    end

    // Out-of-range reads return zero; RDW_NEW forwards the colliding port A write to B.
    always_comb begin
        rdata_a = a_hit ? mem[idx_a] : '0;
        rdata_b = '0;
        if (b_hit) begin
            if (RDW_MODE == RDW_NEW && a_wr && addra == addrb) rdata_b = dina;
            else                                               rdata_b = mem[idx_b];
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            douta_s0  <= '0;
            doutb_s0  <= '0;
            valida_s0 <= 1'b0;
            validb_s0 <= 1'b0;
        end else begin
            valida_s0 <= a_rd;
            validb_s0 <= b_rd;
            if (a_rd) douta_s0 <= rdata_a;
            if (b_rd) doutb_s0 <= rdata_b;
        end
    end

    ram_out_stage #(.WIDTH(DATA_WIDTH), .ENABLE(OUT_REG != 0)) u_out_a (
        .clk   (clka),
        .rst   (rsta),
        .d_in  (douta_s0),
        .v_in  (valida_s0),
        .d_out (douta),
        .v_out (valida)
    );

    ram_out_stage #(.WIDTH(DATA_WIDTH), .ENABLE(OUT_REG != 0)) u_out_b (
        .clk   (clka),
        .rst   (rsta),
        .d_in  (doutb_s0),
        .v_in  (validb_s0),
        .d_out (doutb),
        .v_out (validb)
    );

endmodule

// File: tb/tb_ram_tdp_clr.sv
// Directed bench for ram_tdp_clr: unregistered/old-data, registered/new-data and auto-clear instances.
module tb_ram_tdp_clr;

    typedef struct {
        logic       ena, wea;
        logic [4:0] addra;
        logic [7:0] dina;
        logic       enb;
        logic [4:0] addrb;
        logic [7:0] xa;
        logic       va;
        logic [7:0] xb;
        logic       vb;
        logic [7:0] xb_new;
    } vec_t;

    logic       clk = 1'b0;
    logic       rsta, rst2;
    logic       ena, wea, enb, clear_req;
    logic [4:0] addra, addrb;
    logic [7:0] dina;

    logic [7:0] douta0, doutb0, douta1, doutb1, douta2, doutb2;
    logic       valida0, validb0, busy0, done0;
    logic       valida1, validb1, busy1, done1;
    logic       valida2, validb2, busy2, done2;
    logic       zero1 = 1'b0;
    logic [3:0] zero4 = 4'd0;
    logic [7:0] zero8 = 8'd0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_tdp_clr #(.DATA_WIDTH(8), .ADDR_SIZE(5), .MEM_LENGTH(16),
                  .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(0)) u0 (
        .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(douta0), .valida(valida0), .enb(enb), .addrb(addrb), .doutb(doutb0),
        .validb(validb0), .clear_req(clear_req), .busy(busy0), .clear_done(done0));

    ram_tdp_clr #(.DATA_WIDTH(8), .ADDR_SIZE(5), .MEM_LENGTH(16),
                  .OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(0)) u1 (
        .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(douta1), .valida(valida1), .enb(enb), .addrb(addrb), .doutb(doutb1),
        .validb(validb1), .clear_req(clear_req), .busy(busy1), .clear_done(done1));

    ram_tdp_clr #(.DATA_WIDTH(8), .ADDR_SIZE(4), .MEM_LENGTH(16),
                  .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u2 (
        .clka(clk), .rsta(rst2), .ena(zero1), .wea(zero1), .addra(zero4), .dina(zero8),
        .douta(douta2), .valida(valida2), .enb(zero1), .addrb(zero4), .doutb(doutb2),
        .validb(validb2), .clear_req(zero1), .busy(busy2), .clear_done(done2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        ena = 1'b0; wea = 1'b0; addra = '0; dina = '0; enb = 1'b0; addrb = '0;
    endtask

    function automatic vec_t mk(input bit ea, input bit wa, input int aa, input int da,
                                input bit eb, input int ab, input int xa, input bit va,
                                input int xb, input bit vb, input int xbn);
        vec_t v;
        v.ena = ea;  v.wea = wa;  v.addra = 5'(aa); v.dina = 8'(da);
        v.enb = eb;  v.addrb = 5'(ab);
        v.xa = 8'(xa); v.va = va; v.xb = 8'(xb); v.vb = vb; v.xb_new = 8'(xbn);
        return v;
    endfunction

    vec_t vecs[11];

    initial begin
        int  n;
        bit  any_v;

        vecs[0]  = mk(1, 1,  3, 'hA5, 0,  0, 'h00, 0, 'h00, 0, 'h00);
        vecs[1]  = mk(0, 0,  0, 'h00, 1,  3, 'h00, 0, 'hA5, 1, 'hA5);
        vecs[2]  = mk(1, 1,  7, 'h11, 1,  2, 'h00, 0, 'h00, 1, 'h00);
        vecs[3]  = mk(1, 1,  7, 'h3C, 1,  7, 'h00, 0, 'h11, 1, 'h3C);
        vecs[4]  = mk(1, 0,  7, 'h00, 1,  7, 'h3C, 1, 'h3C, 1, 'h3C);
        vecs[5]  = mk(1, 1, 20, 'h77, 1,  4, 'h3C, 0, 'h00, 1, 'h00);
        vecs[6]  = mk(1, 0, 20, 'h00, 1,  4, 'h00, 1, 'h00, 1, 'h00);
        vecs[7]  = mk(1, 0,  3, 'h00, 0,  0, 'hA5, 1, 'h00, 0, 'h00);
        vecs[8]  = mk(1, 1,  3, 'h5A, 1, 31, 'hA5, 0, 'h00, 1, 'h00);
        vecs[9]  = mk(1, 0,  3, 'h00, 0,  0, 'h5A, 1, 'h00, 0, 'h00);
        vecs[10] = mk(0, 0,  0, 'h00, 0,  0, 'h5A, 0, 'h00, 0, 'h00);

        idle();
        clear_req = 1'b0;
        rsta = 1'b1;
        rst2 = 1'b1;
        @(negedge clk);
        step();
        step();
        check("reset u0", {douta0, doutb0, valida0, validb0, busy0, done0}, 0);
        check("reset u1", {douta1, doutb1, valida1, validb1, busy1, done1}, 0);
        check("reset u2", {douta2, doutb2, valida2, validb2, busy2, done2}, 0);
        rsta = 1'b0;
        step();

        // Zero-fill with an ignored write/read pair on an already cleared address
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        n = 0;
        any_v = 1'b0;
        while (busy0 && n < 40) begin
            n++;
            any_v |= valida0 | validb0 | valida1 | validb1;
            if (n == 10) begin
                ena = 1'b1; wea = 1'b1; addra = 5'd2; dina = 8'hFF; enb = 1'b1; addrb = 5'd2;
            end else if (n == 11) begin
                ena = 1'b1; wea = 1'b0; addra = 5'd2;
            end else begin
                idle();
            end
            step();
        end
        check("clear busy cycles", n, 16);
        check("clear_done u0", done0, 1);
        check("clear_done u1 busy u1", {done1, busy1}, 2'b10);
        check("no valid during busy", any_v, 0);

        // Vector table; the first vector is presented in the clear_done cycle
        for (int k = 0; k <= 10; k++) begin
            ena = vecs[k].ena; wea = vecs[k].wea; addra = vecs[k].addra; dina = vecs[k].dina;
            enb = vecs[k].enb; addrb = vecs[k].addrb;
            step();
            if (k == 0) check("clear_done one cycle", {done0, done1}, 0);
            check($sformatf("v%0d u0 port a", k), {valida0, douta0}, {vecs[k].va, vecs[k].xa});
            check($sformatf("v%0d u0 port b", k), {validb0, doutb0}, {vecs[k].vb, vecs[k].xb});
            if (k > 0) begin
                check($sformatf("v%0d u1 port a", k - 1), {valida1, douta1},
                      {vecs[k-1].va, vecs[k-1].xa});
                check($sformatf("v%0d u1 port b", k - 1), {validb1, doutb1},
                      {vecs[k-1].vb, vecs[k-1].xb_new});
            end
        end

        // Fill then stream port B over the full range
        for (int i = 0; i < 16; i++) begin
            ena = 1'b1; wea = 1'b1; addra = 5'(i); dina = 8'(i * 3 + 1);
            step();
        end
        idle();
        for (int i = 0; i <= 16; i++) begin
            enb = (i < 16);
            addrb = 5'(i);
            step();
            if (i < 16) check($sformatf("stream u0 %0d", i), {validb0, doutb0}, {1'b1, 8'(i * 3 + 1)});
            else        check("stream u0 end", validb0, 0);
            if (i > 0)  check($sformatf("stream u1 %0d", i - 1), {validb1, doutb1},
                              {1'b1, 8'((i - 1) * 3 + 1)});
        end
        step();
        check("stream u1 end", validb1, 0);

        // Read in the clear_req cycle drains through the output stage
        clear_req = 1'b1; enb = 1'b1; addrb = 5'd5;
        step();
        clear_req = 1'b0; enb = 1'b0;
        check("drain u0", {busy0, validb0, doutb0}, {2'b11, 8'h10});
        step();
        check("drain u1", {busy1, validb1, doutb1}, {2'b11, 8'h10});
        check("drain u0 single valid", validb0, 0);
        n = 2;
        while (busy0 && n < 40) begin
            step();
            if (busy0) n++;
        end
        check("second clear busy cycles", n, 16);
        check("second clear_done", done0, 1);
        for (int i = 0; i <= 16; i++) begin
            enb = (i < 16);
            addrb = 5'(i);
            step();
            if (i < 16) check($sformatf("cleared addr %0d", i), {validb0, doutb0}, {1'b1, 8'h00});
        end
        idle();

        // Auto-clear after reset, interrupted by reset after five cycles
        rst2 = 1'b0;
        step();
        check("auto clear start", busy2, 1);
        repeat (4) step();
        check("auto clear fifth cycle", busy2, 1);
        rst2 = 1'b1;
        step();
        check("reset mid-clear", {busy2, done2}, 0);
        rst2 = 1'b0;
        step();
        check("auto clear restart", busy2, 1);
        n = 1;
        while (busy2 && n < 40) begin
            step();
            if (busy2) n++;
        end
        check("restart busy cycles", n, 16);
        check("restart clear_done", done2, 1);
        step();
        check("restart clear_done pulse", done2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_tdp_clr.md
# ram_tdp_clr

Parametrised dual-port tensor buffer; successor to the single-port tensor RAM feeding the IMG2COL/GEMM datapath. Port A is read/write with the same enable/write-enable semantics as the existing tensor RAM. Port B is read-only, so the GEMM array can stream operands while the img2col writer fills the buffer. Adds an optional output register stage, read-valid strobes, a selectable read-during-write policy and a hardware zero-fill engine.

## Interface
- DATA_WIDTH, default `DATA_WIDTH: word width in bits.
- ADDR_SIZE, default `ADDR_SIZE: address width in bits.
- MEM_LENGTH, default 2**ADDR_SIZE: number of words; must be ≤ 2**ADDR_SIZE.
- OUT_REG, default 0: 1 adds one output register stage on both ports.
- RDW_MODE, default 0: same-address B read during an A write. 0 = old data, 1 = new data.
- CLEAR_ON_RESET, default 0: 1 starts a zero-fill automatically after reset.

Ports:
- clka, input, 1: single clock; all logic on the rising edge.
- rsta, input, 1: synchronous, active-high reset.
- ena, input, 1: port A enable.
- wea, input, 1: port A write enable; 0 = read.
- addra, input, ADDR_SIZE: port A address.
- dina, input, DATA_WIDTH: port A write data.
- douta, output, DATA_WIDTH: port A read data.
- valida, output, 1: douta updated with a new read result this cycle.
- enb, input, 1: port B read enable.
- addrb, input, ADDR_SIZE: port B address.
- doutb, output, DATA_WIDTH: port B read data.
- validb, output, 1: doutb updated this cycle.
- clear_req, input, 1: pulse to start a zero-fill.
- busy, output, 1: zero-fill in progress.
- clear_done, output, 1: one-cycle pulse when a zero-fill completes.

## Operation
- **State machine:** states IDLE and CLEAR.
  - IDLE→CLEAR on clear_req=1.
  - With CLEAR_ON_RESET=1, IDLE→CLEAR also on the first cycle after rsta deasserts.
  - CLEAR→IDLE after the write to address MEM_LENGTH-1.
- **CLEAR:**
  - Internal counter writes 0 to addresses 0..MEM_LENGTH-1, one word per cycle.
  - busy=1 for the whole state.
  - ena/enb requests are ignored: no write, douta/doutb hold, valida/validb stay 0.
  - clear_req is ignored.
- **IDLE, port A:**
  - ena=1, wea=1 writes dina to mem[addra]; douta holds, no valida.
  - ena=1, wea=0 reads mem[addra] into douta and raises valida.
- **IDLE, port B:** enb=1 reads mem[addrb] into doutb and raises validb.
- **Collisions:**
  - A read and B read to the same address both return the stored word.
  - A write plus B read to the same address: doutb = old word (RDW_MODE=0) or dina (RDW_MODE=1).
- **Addresses:** addra/addrb ≥ MEM_LENGTH: writes dropped, reads return 0, valid still asserted.
- **Reset values:**
  - douta=0, doutb=0, valida=0, validb=0.
  - busy=0, clear_done=0.
  - State IDLE, clear counter 0.
  - Memory contents are not reset.
- **Reset mid-clear:** returns to IDLE with no clear_done. With CLEAR_ON_RESET=1 the fill restarts from address 0.

## Timing
- **Read latency** (enable edge to data/valid): 1 cycle with OUT_REG=0, 2 cycles with OUT_REG=1.
- **Valid strobes:** valida/validb are single-cycle per request. Back-to-back reads give one result per cycle.
- **Clear timing:**
  - clear_req sampled at edge T: busy=1 from T+1.
  - Zero writes occur at edges T+1..T+MEM_LENGTH.
  - busy=0 and clear_done=1 at T+MEM_LENGTH+1, for one cycle.
- **First access after clear:** an access presented in the clear_done cycle is serviced normally.
- **Pipeline drain on clear entry:** with OUT_REG=1, a read issued the cycle before clear entry still completes in the output stage.

## Structure
- Package ram_pkg holds:
  - state typedef (IDLE, CLEAR);
  - RDW_OLD=0 / RDW_NEW=1 constants.
- One sub-module, ram_out_stage: optional data+valid register stage instantiated once per port and controlled by OUT_REG.
- Memory array and clear counter live in the top module.

## Test plan
- **Reset values:** rsta=1 for 2 cycles → all outputs 0, busy=0.
- **Single write/read, OUT_REG=0:** write 0xA5 to addr 3 on A, then enb=1 at addr 3 → doutb=0xA5, validb=1 exactly 1 cycle later. With OUT_REG=1, same result 2 cycles later.
- **Collision:** A writes 0x3C to addr 7 (old 0x11) while B reads addr 7 → doutb=0x11 with RDW_MODE=0, 0x3C with RDW_MODE=1.
- **Clear, MEM_LENGTH=16:**
  - clear_req pulse → busy high for 16 cycles; clear_done pulses on cycle 17.
  - Reads of every address return 0.
  - Accesses during busy produce no valid and no writes.
- **Reset mid-clear, CLEAR_ON_RESET=1:** rsta after 5 clear cycles → fill restarts at address 0; clear_done only after the full 16 cycles.
- **Stream:** enb held high over addrs 0..15 → 16 consecutive validb pulses with in-order data.
